// File: rtl/cache_port_arbiter_pkg.sv
// Shared word type plus the arbiter's state/source enums and default timeout.
// Both packages live in this one file so every arbiter file can import them.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

package rv32i_cache_types;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

  localparam int ARB_TIMEOUT_DEFAULT = 256;
endpackage

// File: rtl/cache_port_arbiter_rr_pick2.sv
// Two-way tie-breaker: decides whether the data side wins this arbitration.
module rr_pick2
  import rv32i_cache_types::*;
(
  input  logic     req_i,
  input  logic     req_d,
  input  arb_src_t last_grant,
  input  logic     fixed_prio,
  output logic     grant_d
);

  // D wins when it is alone, or on a tie when prioritised or when I was served last.
  assign grant_d = req_d && (!req_i || fixed_prio || (last_grant == SRC_I));

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one word-granular cache port between fetch (I) and data (D) requesters,
// one transaction at a time, with a sticky timeout flag for a stuck cache.
module cache_port_arbiter
  import rv32i_types::*;
  import rv32i_cache_types::*;
#(
  parameter bit FIXED_PRIO     = 1'b0,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_read,
  input  rv32i_word  i_address,
  output rv32i_word  i_rdata,
  output logic       i_resp,
  input  logic       d_read,
  input  logic       d_write,
  input  rv32i_word  d_address,
  input  rv32i_word  d_wdata,
  input  logic [3:0] d_byte_enable,
  output rv32i_word  d_rdata,
  output logic       d_resp,
  output logic       mem_read,
  output logic       mem_write,
  output rv32i_word  mem_address,
  output rv32i_word  mem_wdata,
  output logic [3:0] mem_byte_enable,
  input  rv32i_word  mem_rdata,
  input  logic       mem_resp,
  output logic       timeout_err
);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  arb_src_t         r_last_grant;
  logic             r_write;
  rv32i_word        r_addr;
  rv32i_word        r_wdata;
  logic [3:0]       r_be;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout_err;

  logic w_req_i, w_req_d, w_grant_d, w_capture, w_busy;

  assign w_req_i   = i_read;
  assign w_req_d   = d_read || d_write;
  assign w_capture = (r_state == IDLE) && (w_req_i || w_req_d);
  assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);

  rr_pick2 u_pick (
    .req_i      (w_req_i),
    .req_d      (w_req_d),
    .last_grant (r_last_grant),
    .fixed_prio (FIXED_PRIO),
    .grant_d    (w_grant_d)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d)    w_state_next = BUSY_D;
        else if (w_req_i) w_state_next = BUSY_I;
      end
      BUSY_I, BUSY_D: if (mem_resp) w_state_next = DONE;
      DONE:           w_state_next = IDLE;
      default:        w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state       <= IDLE;
      r_last_grant  <= SRC_I;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        // A simultaneous d_read/d_write is resolved as a write.
        r_last_grant <= w_grant_d ? SRC_D : SRC_I;
        r_write      <= w_grant_d && d_write;
        r_addr       <= {(w_grant_d ? d_address[31:2] : i_address[31:2]), 2'b00};
        r_wdata      <= w_grant_d ? d_wdata : '0;
        r_be         <= (w_grant_d && d_write) ? d_byte_enable : 4'b0000;
        r_wait_cnt   <= '0;
      end else if (w_busy && !mem_resp && (r_wait_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) r_timeout_err <= 1'b1;
      end
    end
  end

  assign mem_read        = w_busy && !r_write;
  assign mem_write       = w_busy && r_write;
  assign mem_address     = w_busy ? r_addr  : '0;
  assign mem_wdata       = w_busy ? r_wdata : '0;
  assign mem_byte_enable = w_busy ? r_be    : 4'b0000;

  assign i_resp      = !rst && mem_resp && (r_state == BUSY_I);
  assign d_resp      = !rst && mem_resp && (r_state == BUSY_D);
  assign i_rdata     = i_resp ? mem_rdata : '0;
  assign d_rdata     = d_resp ? mem_rdata : '0;
  assign timeout_err = r_timeout_err;

endmodule
